decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 reset_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 in_valid  in  1  fetch offers an instruction.
REQ-004 in_ready  out  1  stage accepts; transfer when in_valid && in_ready.
REQ-005 instr  in  32  DLX instruction word.
REQ-006 pc  in  32  address of instr.
REQ-007 out_valid  out  1  decoded entry held in output register.
REQ-008 out_ready  in  1  execute consumes; transfer when out_valid && out_ready.
REQ-009 Rs1, Rs2, Rd  out  5 each  register numbers driven to the register file.
REQ-010 reg_s_enable  out  1  entry writes Rd at writeback.
REQ-011 imm  out  32  extended immediate or jump offset.
REQ-012 alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 LHI.
REQ-013 is_load, is_store, is_branch, is_jump, illegal  out  1 each  class flags.
REQ-014 pc_out  out  32  pc of held entry.
REQ-015 wb_valid  in  1, wb_rd  in  5  writeback retires register wb_rd.
REQ-016 flush  in  1  discard held entry (taken branch).

Function
REQ-017 Fields: op=instr[31:26], rs1=[25:21]; R-type (op 0) rs2=[20:16], rd=[15:11], func=[5:0]; I-type rd=[20:16]; J-type offset=[25:0].
REQ-018 R-type func: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x04 SLL, 0x06 SRL, 0x2A SLT; reg_s_enable=1.
REQ-019 I-type op: 0x08 ADDI, 0x0C ANDI, 0x0D ORI, 0x0E XORI, 0x0F LHI, 0x23 LW (ADD, is_load), 0x2B SW (ADD, is_store, Rs2=instr[20:16], no write), 0x04 BEQZ, 0x05 BNEZ (is_branch, no write).
REQ-020 imm: sign-extended [15:0] for ADDI, LW, SW, BEQZ, BNEZ; zero-extended for ANDI, ORI, XORI; [15:0]<<16 for LHI; sign-extended [25:0] for J/JAL.
REQ-021 J (0x02) and JAL (0x03): is_jump=1; JAL Rd=31, reg_s_enable=1.
REQ-022 Any other op/func: illegal=1, reg_s_enable=0, all other class flags 0; entry still passes downstream.
REQ-023 reg_s_enable forced 0 whenever Rd==0.
REQ-024 Latency: accepted instruction appears on outputs the cycle after acceptance.
REQ-025 Scoreboard: 32 pending bits; bit 0 never set.
REQ-026 Hazard when any used source (Rs1; Rs2 for R-type and SW) has pending bit set in the registered scoreboard.
REQ-027 in_ready = !hazard && !flush && (!out_valid || out_ready).
REQ-028 On acceptance, output register loads; pending[Rd] sets if reg_s_enable.
REQ-029 wb_valid clears pending[wb_rd]; same-cycle set and clear of same index: set wins.
REQ-030 Output held stable while out_valid && !out_ready.
REQ-031 flush: out_valid clears next cycle; if held entry had reg_s_enable, its pending bit clears; no input accepted that cycle.

Reset
REQ-032 reset_n low at clk edge: out_valid=0, all pending bits 0, all decoded outputs 0, regardless of in-flight handshakes; in_ready=0 while reset_n low.

Verification
REQ-033 ADD r3,r1,r2 (0x00221820) accepted -> next cycle Rs1=1, Rs2=2, Rd=3, alu_op=0, reg_s_enable=1, pending[3]=1.
REQ-034 ADDI r4,r3,-1 (0x2064FFFF) offered while pending[3]=1 -> in_ready=0 until wb_valid, wb_rd=3; accepted the cycle after, imm=0xFFFFFFFF.
REQ-035 ORI r5,r0,0x8000 -> imm=0x00008000; LHI r6,0x1234 -> imm=0x12340000, alu_op=8.
REQ-036 JAL offset 0x3FFFFFC -> Rd=31, imm=0xFFFFFFFC, is_jump=1; ADDI r0,r1,5 -> reg_s_enable=0, pending unchanged.
REQ-037 out_ready=0 for 3 cycles with entry held -> outputs stable, in_ready=0; then flush -> out_valid=0, held entry's pending bit cleared.
REQ-038 reset_n low for one cycle with out_valid=1, pending[7]=1 -> out_valid=0, pending all 0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// DLX decode stage: field extraction, control decode and a register scoreboard
// that stalls instructions whose source registers still await writeback.
module decode_stage (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  Rs1,
   output logic [4:0]  Rs2,
   output logic [4:0]  Rd,
   output logic        reg_s_enable,
   output logic [31:0] imm,
   output logic [3:0]  alu_op,
   output logic        is_load,
   output logic        is_store,
   output logic        is_branch,
   output logic        is_jump,
   output logic        illegal,
   output logic [31:0] pc_out,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        flush
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
      ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SLT = 4'd7, ALU_LHI = 4'd8
   } alu_op_e;

   logic [31:0] pending;

   logic [5:0]  op;
   logic [5:0]  func;
   logic [31:0] sext16;
   logic [31:0] zext16;
   logic [31:0] sext26;

   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic        d_write, d_wen, d_use_rs2;
   logic [31:0] d_imm;
   alu_op_e     d_alu;
   logic        d_load, d_store, d_branch, d_jump, d_illegal;

   logic        hazard;
   logic        accept;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   assign op     = instr[31:26];
   assign func   = instr[5:0];
   assign sext16 = {{16{instr[15]}}, instr[15:0]};
   assign zext16 = {16'd0, instr[15:0]};
   assign sext26 = {{6{instr[25]}}, instr[25:0]};

   // Unused register fields decode to 0 so they never trip the hazard check.
   always_comb begin
      d_rs1     = 5'd0;
      d_rs2     = 5'd0;
      d_rd      = 5'd0;
      d_write   = 1'b0;
      d_use_rs2 = 1'b0;
      d_imm     = 32'd0;
      d_alu     = ALU_ADD;
      d_load    = 1'b0;
      d_store   = 1'b0;
      d_branch  = 1'b0;
      d_jump    = 1'b0;
      d_illegal = 1'b0;
      case (op)
         6'h00: begin
            d_rs1     = instr[25:21];
            d_rs2     = instr[20:16];
            d_rd      = instr[15:11];
            d_write   = 1'b1;
            d_use_rs2 = 1'b1;
            case (func)
               6'h20:   d_alu = ALU_ADD;
               6'h22:   d_alu = ALU_SUB;
               6'h24:   d_alu = ALU_AND;
               6'h25:   d_alu = ALU_OR;
               6'h26:   d_alu = ALU_XOR;
               6'h04:   d_alu = ALU_SLL;
               6'h06:   d_alu = ALU_SRL;
               6'h2A:   d_alu = ALU_SLT;
               default: begin
                  d_rs1     = 5'd0;
                  d_rs2     = 5'd0;
                  d_rd      = 5'd0;
                  d_write   = 1'b0;
                  d_use_rs2 = 1'b0;
                  d_illegal = 1'b1;
               end
            endcase
         end
         6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
            d_rs1   = instr[25:21];
            d_rd    = instr[20:16];
            d_write = 1'b1;
            case (op)
               6'h0C:   begin d_alu = ALU_AND; d_imm = zext16; end
               6'h0D:   begin d_alu = ALU_OR;  d_imm = zext16; end
               6'h0E:   begin d_alu = ALU_XOR; d_imm = zext16; end
               6'h0F:   begin d_alu = ALU_LHI; d_imm = {instr[15:0], 16'd0}; end
               6'h23:   begin d_load = 1'b1;   d_imm = sext16; end
               default: d_imm = sext16;
            endcase
         end
         6'h2B: begin
            d_rs1     = instr[25:21];
            d_rs2     = instr[20:16];
            d_use_rs2 = 1'b1;
            d_store   = 1'b1;
            d_imm     = sext16;
         end
         6'h04, 6'h05: begin
            d_rs1    = instr[25:21];
            d_branch = 1'b1;
            d_imm    = sext16;
         end
         6'h02: begin
            d_jump = 1'b1;
            d_imm  = sext26;
         end
         6'h03: begin
            d_jump  = 1'b1;
            d_rd    = 5'd31;
            d_write = 1'b1;
            d_imm   = sext26;
         end
         default: d_illegal = 1'b1;
      endcase
   end

   assign d_wen    = d_write && (d_rd != 5'd0);
   assign hazard   = pending[d_rs1] || (d_use_rs2 && pending[d_rs2]);
   assign in_ready = reset_n && !hazard && !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // A new reservation beats a writeback or flush release of the same register.
   always_comb begin
      set_mask = 32'd0;
      clr_mask = 32'd0;
      if (accept && d_wen)
         set_mask = 32'd1 << d_rd;
      if (wb_valid)
         clr_mask = clr_mask | (32'd1 << wb_rd);
      if (flush && out_valid && reg_s_enable)
         clr_mask = clr_mask | (32'd1 << Rd);
   end

   // Output register and scoreboard; a flush drops the held entry without accepting.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending      <= 32'd0;
         out_valid    <= 1'b0;
         Rs1          <= 5'd0;
         Rs2          <= 5'd0;
         Rd           <= 5'd0;
         reg_s_enable <= 1'b0;
         imm          <= 32'd0;
         alu_op       <= 4'd0;
         is_load      <= 1'b0;
         is_store     <= 1'b0;
         is_branch    <= 1'b0;
         is_jump      <= 1'b0;
         illegal      <= 1'b0;
         pc_out       <= 32'd0;
      end else begin
         pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid    <= 1'b1;
            Rs1          <= d_rs1;
            Rs2          <= d_rs2;
            Rd           <= d_rd;
            reg_s_enable <= d_wen;
            imm          <= d_imm;
            alu_op       <= d_alu;
            is_load      <= d_load;
            is_store     <= d_store;
            is_branch    <= d_branch;
            is_jump      <= d_jump;
            illegal      <= d_illegal;
            pc_out       <= pc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
